// File: rtl/lenet_ctrl_defs.sv
// ---------------------------------------------------------------------------
// lenet_ctrl_defs
// Shared definitions for the layer sequencer.
//   seqState_e  : sequencer FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   calcOutW()  : output feature-map width for a valid (unpadded) convolution
//   calcNWin()  : number of windows issued in one layer pass
// ---------------------------------------------------------------------------
package lenet_ctrl_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seqState_e;

   // A KxK kernel slid over an imgW x imgW map without padding
   // produces imgW-K+1 positions along each axis.
   function automatic int calcOutW(input int imgW, input int k);
      return imgW - k + 1;
   endfunction

   function automatic int calcNWin(input int imgW, input int k);
      int w;
      w = calcOutW(imgW, k);
      return w * w;
   endfunction

endpackage

// File: rtl/valid_delay_line.sv
// ---------------------------------------------------------------------------
// valid_delay_line
// DEPTH-stage 1-bit shift register that mirrors the datapath latency.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   en_i         : shift enable; when low every stage holds
//   valid_i      : bit entering stage 0
//   valid_o      : bit leaving the last stage
//   occupied_o   : some stage currently holds a 1
//   emptyNext_o  : every stage will hold 0 after this clock edge
// ---------------------------------------------------------------------------
module valid_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic valid_i,
   output logic valid_o,
   output logic occupied_o,
   output logic emptyNext_o
);

   logic [DEPTH-1:0] stages_q;
   logic [DEPTH-1:0] stages_d;

   // Next contents of the line. Shifting left and then overwriting bit 0
   // keeps this correct even for a single-stage line, where the shift
   // simply discards the old bit.
   always_comb begin
      stages_d = stages_q;
      if (en_i) begin
         stages_d    = stages_q << 1;
         stages_d[0] = valid_i;
      end
   end

   // Stage register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         stages_q <= '0;
      end else begin
         stages_q <= stages_d;
      end
   end

   assign valid_o     = stages_q[DEPTH-1];
   assign occupied_o  = |stages_q;
   assign emptyNext_o = ~|stages_d;

endmodule

// File: rtl/layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// layer_seq_ctrl
// Walks every KxK window of an IMG_W x IMG_W feature map in raster order,
// issues one window per non-stalled cycle and tracks the results coming
// back out of a PIPE_LAT-deep datapath.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : one-cycle request to run a pass (only heard in IDLE)
//   stall               : downstream not ready; freezes the whole sequencer
//   busy                : sequencer is not idle
//   done                : one-cycle pulse when a pass finishes
//   win_valid           : a window is issued this cycle
//   win_row, win_col    : output-row/column of the issued window
//   pix_addr            : top-left pixel address of the issued window
//   out_valid           : datapath result valid this cycle
//   out_addr            : linear index of the current result
// ---------------------------------------------------------------------------
module layer_seq_ctrl
   import lenet_ctrl_defs::*;
#(
   parameter int IMG_W    = 28,
   parameter int K        = 5,
   parameter int PIPE_LAT = 3,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              win_valid,
   output logic [ADDR_W-1:0] win_row,
   output logic [ADDR_W-1:0] win_col,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr
);

   localparam int OUT_W = calcOutW(IMG_W, K);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(K);

   seqState_e         state_q;
   seqState_e         state_d;
   logic [ADDR_W-1:0] row_q;
   logic [ADDR_W-1:0] row_d;
   logic [ADDR_W-1:0] col_q;
   logic [ADDR_W-1:0] col_d;
   logic [ADDR_W-1:0] pix_q;
   logic [ADDR_W-1:0] pix_d;
   logic [ADDR_W-1:0] outAddr_q;
   logic [ADDR_W-1:0] outAddr_d;

   logic winValid;
   logic outValid;
   logic pipeOut;
   logic pipeOccupied;
   logic pipeEmptyNext;

   assign winValid = (state_q == RUN) && !stall;
   assign outValid = pipeOut && !stall;

   // The valid pipeline only advances on non-stalled cycles, so a result
   // appears exactly PIPE_LAT enabled cycles after its window was issued.
   valid_delay_line #(
      .DEPTH (PIPE_LAT)
   ) u_validPipe (
      .clk         (clk),
      .reset       (reset),
      .en_i        (!stall),
      .valid_i     (winValid),
      .valid_o     (pipeOut),
      .occupied_o  (pipeOccupied),
      .emptyNext_o (pipeEmptyNext)
   );

   // Next-state and counter logic. The pixel address is stepped
   // incrementally instead of multiplied: +1 along a row, and at a row wrap
   // the jump from (r, OUT_W-1) to (r+1, 0) is IMG_W-(OUT_W-1) = K.
   // DRAIN leaves on the edge that empties the valid pipeline, so DONE
   // follows the final result by exactly one cycle. DONE ignores stall.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      pix_d     = pix_q;
      outAddr_d = outAddr_q;

      if (outValid) begin
         outAddr_d = outAddr_q + ONE;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               row_d     = '0;
               col_d     = '0;
               pix_d     = '0;
               outAddr_d = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               if (col_q == LAST_IDX) begin
                  col_d = '0;
                  if (row_q == LAST_IDX) begin
                     row_d   = '0;
                     pix_d   = '0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + ONE;
                     pix_d = pix_q + ROW_STEP;
                  end
               end else begin
                  col_d = col_q + ONE;
                  pix_d = pix_q + ONE;
               end
            end
         end
         DRAIN: begin
            if (!pipeOccupied || (!stall && pipeEmptyNext)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset, which aborts any
   // pass in progress without producing a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         pix_q     <= '0;
         outAddr_q <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         pix_q     <= pix_d;
         outAddr_q <= outAddr_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign win_valid = winValid;
   assign win_row   = row_q;
   assign win_col   = col_q;
   assign pix_addr  = pix_q;
   assign out_valid = outValid;
   assign out_addr  = outAddr_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_layer_seq_ctrl
// Self-checking bench for layer_seq_ctrl at default parameters. A per-cycle
// reference model (window index, enabled-cycle count and a queue of issue
// times) predicts every output; a vector table and directed passes check
// the cycle-exact corner cases.
// ---------------------------------------------------------------------------
module tb_layer_seq_ctrl;

   localparam int IMG_W    = 28;
   localparam int K        = 5;
   localparam int PIPE_LAT = 3;
   localparam int ADDR_W   = 10;
   localparam int OUT_W    = IMG_W - K + 1;
   localparam int N_WIN    = OUT_W * OUT_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stall;
   logic              busy;
   logic              done;
   logic              win_valid;
   logic [ADDR_W-1:0] win_row;
   logic [ADDR_W-1:0] win_col;
   logic [ADDR_W-1:0] pix_addr;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;

   always #5 clk = ~clk;

   layer_seq_ctrl #(
      .IMG_W    (IMG_W),
      .K        (K),
      .PIPE_LAT (PIPE_LAT),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stall     (stall),
      .busy      (busy),
      .done      (done),
      .win_valid (win_valid),
      .win_row   (win_row),
      .win_col   (win_col),
      .pix_addr  (pix_addr),
      .out_valid (out_valid),
      .out_addr  (out_addr)
   );

   int checkCount = 0;
   int passCount  = 0;
   bit checking   = 1'b0;

   // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done
   int mPhase;
   int mWin;
   int mEn;
   int mOut;
   int mIssueQ[$];

   // Per-pass statistics taken from DUT outputs, cycle numbers relative to
   // the cycle in which start is driven
   int relCyc;
   int firstWv, lastWv, wvCount, firstOv, lastOv, ovCount;
   int doneCount, doneCyc, firstBusy, lastBusy, busyCount;
   int firstOvAddr, lastOvAddr, firstWinRow, firstWinCol;
   int win25Row, win25Col, win25Pix, lastRow, lastCol, lastPix;
   int stallWinCount, busyAfterReset;
   logic [3:0]        snapFlags;
   logic [ADDR_W-1:0] snapRow, snapCol, snapPix, snapAddr;

   typedef struct {
      logic       rst;
      logic       st;
      logic       sl;
      logic       eBusy;
      logic       eDone;
      logic       eWv;
      logic       eOv;
      logic [9:0] eAddr;
   } vec_t;

   vec_t vecs[13];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPhase = 0;
      mWin   = 0;
      mEn    = 0;
      mOut   = 0;
      mIssueQ.delete();
   endtask

   task automatic clearStats();
      relCyc = 0;
      firstWv = -1; lastWv = -1; wvCount = 0;
      firstOv = -1; lastOv = -1; ovCount = 0;
      doneCount = 0; doneCyc = -1;
      firstBusy = -1; lastBusy = -1; busyCount = 0;
      firstOvAddr = -1; lastOvAddr = -1; firstWinRow = -1; firstWinCol = -1;
      win25Row = -1; win25Col = -1; win25Pix = -1;
      lastRow = -1; lastCol = -1; lastPix = -1;
      stallWinCount = 0; busyAfterReset = 0;
      snapFlags = 4'hF; snapRow = '1; snapCol = '1; snapPix = '1; snapAddr = '1;
   endtask

   // Drive one cycle of inputs, compare against the model, record stats,
   // then advance the model across the coming clock edge.
   task automatic applyStimulus(input logic rst, input logic st, input logic sl);
      bit expWv;
      bit expOv;
      int r;
      int c;
      @(negedge clk);
      reset = rst;
      start = st;
      stall = sl;
      #2;
      expWv = (mPhase == 1) && !sl;
      expOv = !sl && (mPhase == 1 || mPhase == 2) && (mIssueQ.size() > 0)
              && (mIssueQ[0] + PIPE_LAT == mEn);
      if (checking) begin
         checkOutput("busy", 32'(busy), 32'(mPhase != 0));
         checkOutput("done", 32'(done), 32'(mPhase == 3));
         checkOutput("win_valid", 32'(win_valid), 32'(expWv));
         checkOutput("out_valid", 32'(out_valid), 32'(expOv));
         checkOutput("out_addr", 32'(out_addr), 32'(mOut));
         if (expWv) begin
            r = mWin / OUT_W;
            c = mWin % OUT_W;
            checkOutput("win_row", 32'(win_row), 32'(r));
            checkOutput("win_col", 32'(win_col), 32'(c));
            checkOutput("pix_addr", 32'(pix_addr), 32'(r * IMG_W + c));
         end
      end

      if (win_valid === 1'b1) begin
         wvCount++;
         if (firstWv < 0) begin
            firstWv     = relCyc;
            firstWinRow = int'(win_row);
            firstWinCol = int'(win_col);
         end
         lastWv = relCyc;
         if (wvCount == 25) begin
            win25Row = int'(win_row); win25Col = int'(win_col); win25Pix = int'(pix_addr);
         end
         if (wvCount == N_WIN) begin
            lastRow = int'(win_row); lastCol = int'(win_col); lastPix = int'(pix_addr);
         end
      end
      if (out_valid === 1'b1) begin
         ovCount++;
         if (firstOv < 0) begin
            firstOv     = relCyc;
            firstOvAddr = int'(out_addr);
         end
         lastOv     = relCyc;
         lastOvAddr = int'(out_addr);
      end
      if (done === 1'b1) begin
         doneCount++;
         doneCyc = relCyc;
      end
      if (busy === 1'b1) begin
         busyCount++;
         if (firstBusy < 0) firstBusy = relCyc;
         lastBusy = relCyc;
         if (relCyc > 100) busyAfterReset++;
      end
      if (relCyc >= 10 && relCyc <= 14 && (win_valid !== 1'b0 || out_valid !== 1'b0)) begin
         stallWinCount++;
      end
      if (relCyc == 101) begin
         snapFlags = {busy, done, win_valid, out_valid};
         snapRow = win_row; snapCol = win_col; snapPix = pix_addr; snapAddr = out_addr;
      end
      relCyc++;

      if (rst) begin
         modelReset();
      end else begin
         case (mPhase)
            0: begin
               if (st) begin
                  mPhase = 1; mWin = 0; mEn = 0; mOut = 0;
                  mIssueQ.delete();
               end
            end
            1, 2: begin
               if (!sl) begin
                  if (expWv) begin
                     mIssueQ.push_back(mEn);
                     mWin++;
                     if (mWin == N_WIN) mPhase = 2;
                  end
                  if (expOv) begin
                     void'(mIssueQ.pop_front());
                     mOut++;
                  end
                  mEn++;
                  if (mPhase == 2 && mIssueQ.size() == 0) mPhase = 3;
               end
            end
            default: mPhase = 0;
         endcase
      end
   endtask

   // One pass starting with start in cycle 0. mode: 0 plain, 1 stall 10..14,
   // 2 stall over the drain, 3 random stall/start, 4 reset at 100,
   // 5 extra starts at 50 and 580.
   task automatic runPass(input int mode, input int limit);
      clearStats();
      for (int c = 0; c < limit; c++) begin
         logic r;
         logic s;
         logic l;
         r = 1'b0;
         s = (c == 0);
         l = 1'b0;
         case (mode)
            1: l = (c >= 10 && c <= 14);
            2: l = (c >= 577 && c <= 580);
            3: begin
               l = ($urandom_range(0, 3) == 0);
               s = (c == 0) || (c < 500 && $urandom_range(0, 40) == 0);
            end
            4: r = (c == 100);
            5: s = (c == 0 || c == 50 || c == 580);
            default: ;
         endcase
         applyStimulus(r, s, l);
         if (mode != 5 && doneCount > 0 && c >= doneCyc + 3) break;
      end
   endtask

   task automatic checkNominal();
      checkOutput("first_win_cycle", 32'(firstWv), 32'd1);
      checkOutput("last_win_cycle", 32'(lastWv), 32'd576);
      checkOutput("win_count", 32'(wvCount), 32'(N_WIN));
      checkOutput("first_out_cycle", 32'(firstOv), 32'd4);
      checkOutput("last_out_cycle", 32'(lastOv), 32'd579);
      checkOutput("out_count", 32'(ovCount), 32'(N_WIN));
      checkOutput("done_count", 32'(doneCount), 32'd1);
      checkOutput("done_cycle", 32'(doneCyc), 32'd580);
      checkOutput("busy_first", 32'(firstBusy), 32'd1);
      checkOutput("busy_last", 32'(lastBusy), 32'd580);
      checkOutput("busy_count", 32'(busyCount), 32'd580);
      checkOutput("first_win_row", 32'(firstWinRow), 32'd0);
      checkOutput("first_win_col", 32'(firstWinCol), 32'd0);
      checkOutput("first_out_addr", 32'(firstOvAddr), 32'd0);
      checkOutput("win25_row", 32'(win25Row), 32'd1);
      checkOutput("win25_col", 32'(win25Col), 32'd0);
      checkOutput("win25_pix", 32'(win25Pix), 32'd28);
      checkOutput("last_row", 32'(lastRow), 32'd23);
      checkOutput("last_col", 32'(lastCol), 32'd23);
      checkOutput("last_pix", 32'(lastPix), 32'd667);
      checkOutput("last_out_addr", 32'(lastOvAddr), 32'd575);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      modelReset();
      clearStats();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checking = 1'b1;

      // rst st sl | busy done wv ov addr
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].sl);
         checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eBusy));
         checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].eDone));
         checkOutput($sformatf("vec%0d_win_valid", i), 32'(win_valid), 32'(vecs[i].eWv));
         checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eOv));
         checkOutput($sformatf("vec%0d_out_addr", i), 32'(out_addr), 32'(vecs[i].eAddr));
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] nominal pass");
      runPass(0, 700);
      checkNominal();

      $display("[TB] stall in cycles 10..14");
      runPass(1, 700);
      checkOutput("stall_window_activity", 32'(stallWinCount), 32'd0);
      checkOutput("stall_last_win", 32'(lastWv), 32'd581);
      checkOutput("stall_done_cycle", 32'(doneCyc), 32'd585);
      checkOutput("stall_out_count", 32'(ovCount), 32'(N_WIN));

      $display("[TB] stall across drain");
      runPass(2, 700);
      checkOutput("drain_last_out", 32'(lastOv), 32'd583);
      checkOutput("drain_last_addr", 32'(lastOvAddr), 32'd575);
      checkOutput("drain_done_follows", 32'(doneCyc - lastOv), 32'd1);
      checkOutput("drain_done_cycle", 32'(doneCyc), 32'd584);
      checkOutput("drain_out_count", 32'(ovCount), 32'(N_WIN));

      $display("[TB] reset mid-pass");
      runPass(4, 130);
      checkOutput("rst_done_count", 32'(doneCount), 32'd0);
      checkOutput("rst_busy_after", 32'(busyAfterReset), 32'd0);
      checkOutput("rst_flags", 32'(snapFlags), 32'd0);
      checkOutput("rst_row", 32'(snapRow), 32'd0);
      checkOutput("rst_col", 32'(snapCol), 32'd0);
      checkOutput("rst_pix", 32'(snapPix), 32'd0);
      checkOutput("rst_out_addr", 32'(snapAddr), 32'd0);
      runPass(0, 700);
      checkNominal();

      $display("[TB] start while busy");
      runPass(5, 640);
      checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
      checkOutput("busy_start_done_cycle", 32'(doneCyc), 32'd580);
      checkOutput("busy_start_busy_count", 32'(busyCount), 32'd580);

      for (int p = 0; p < 3; p++) begin
         $display("[TB] random stall pass %0d", p);
         runPass(3, 2500);
         checkOutput("rand_win_count", 32'(wvCount), 32'(N_WIN));
         checkOutput("rand_out_count", 32'(ovCount), 32'(N_WIN));
         checkOutput("rand_done_count", 32'(doneCount), 32'd1);
         checkOutput("rand_last_addr", 32'(lastOvAddr), 32'd575);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
